// File: rtl/serial_adder_32_bit_pkg.sv
// Shared definitions for the digit-serial adder.
//   WIDTH_DEF / DIGIT_DEF : default operand width and bits added per cycle
//   STEPS                 : digit steps per addition at the defaults
//   state_e               : FSM state encoding
package serial_adder_32_bit_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DIGIT_DEF = 4;
  localparam int unsigned STEPS     = WIDTH_DEF / DIGIT_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_adder_32_bit_adder_4_bit.sv
// Combinational digit adder used by the serial adder.
// Ports:
//   a, b  : digit operands
//   cin   : carry in
//   sum   : digit sum
//   cout  : carry out of the digit
module adder_4_bit
  import serial_adder_32_bit_pkg::*;
#(
  parameter int unsigned W = DIGIT_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/serial_adder_32_bit.sv
// Digit-serial adder: computes a + b + cin, DIGIT bits per clock.
// Ports:
//   clock, clear       : clock and synchronous active-high reset
//   start, a, b, cin   : request and operands, latched when accepted in IDLE
//   sum, cout, overflow: registered result, qualified by done
//   busy, done         : operation in progress / one-cycle result-valid pulse
//
// state | meaning
// IDLE  | waiting for start, result outputs hold
// RUN   | one digit added per edge, STEPS edges total
// DONE  | result valid for one cycle, then back to IDLE
module serial_adder_32_bit
  import serial_adder_32_bit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIGIT = DIGIT_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N_STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DIGIT-1:0]   dig_sum;
  logic               dig_cout;

  adder_4_bit #(.W(DIGIT)) u_digit (
    .a    (a_sh_q[DIGIT-1:0]),
    .b    (b_sh_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          // operands get shifted away, so keep their sign bits for overflow
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        // new digit enters at the top; after N_STEPS shifts digit 0 is at the bottom
        sum_d   = {dig_sum, sum_q[WIDTH-1:DIGIT]};
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_STEPS - 1)) begin
          cout_d  = dig_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (dig_sum[DIGIT-1] != a_msb_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_adder_32_bit.sv
module tb_serial_adder_32_bit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_i   = '0;
  logic [31:0] b_i   = '0;
  logic        cin_i = 1'b0;
  logic [31:0] sum;
  logic        cout, overflow, busy, done;

  int n_chk = 0;
  int n_err = 0;

  serial_adder_32_bit dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .a        (a_i),
    .b        (b_i),
    .cin      (cin_i),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accepts an operation at the next edge, then scrambles the inputs so a
  // result that depends on them after the start edge shows up as wrong.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    a_i   = av;
    b_i   = bv;
    cin_i = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
    cin_i = ~cv;
  endtask

  // Watches ncyc edges, optionally pulsing start before edge spur_at,
  // and captures the result at the first done pulse.
  task automatic watch(input int ncyc, input int spur_at, output int first, output int ndone,
                       output logic [31:0] s, output logic c, output logic o);
    first = -1;
    ndone = 0;
    s = '0;
    c = 1'b0;
    o = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      if (i == spur_at) start = 1'b1;
      tick();
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = i;
          s = sum;
          c = cout;
          o = overflow;
        end
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [31:0] es, input logic ec, input logic eo,
                         input int spur_at);
    int first, ndone;
    logic [31:0] s;
    logic c, o;
    launch(av, bv, cv);
    chk({tag, ".busy"}, busy, 1);
    watch(20, spur_at, first, ndone, s, c, o);
    chk({tag, ".lat"}, first, 8);
    chk({tag, ".ndone"}, ndone, 1);
    chk({tag, ".sum"}, s, es);
    chk({tag, ".cout"}, c, ec);
    chk({tag, ".ovf"}, o, eo);
    chk({tag, ".hold"}, sum, es);
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    int first, second, ndone;
    logic [31:0] s, s2;
    logic c, o;

    tick();
    tick();
    clear = 1'b0;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    chk("rst.ovf", overflow, 0);

    // idle with no start holds
    tick();
    tick();
    chk("idle.busy", busy, 0);

    run_vec("v4p2",  32'h0000_0004, 32'h0000_0002, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 0);
    run_vec("vffp1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_vec("v7fp1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
    run_vec("vsub0", 32'h0444_4444, 32'hFBBB_BBBB, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 3);
    run_vec("vmix",  32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0);
    run_vec("vneg",  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 0);
    run_vec("vsub2", 32'h0000_0005, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);

    // clear on the 4th RUN edge aborts the operation
    launch(32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.sum", sum, 0);
    watch(10, 0, first, ndone, s, c, o);
    chk("abort.ndone", ndone, 0);

    // clear wins over start at the same edge
    a_i   = 32'h1;
    b_i   = 32'h1;
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    chk("prio.busy", busy, 0);

    // back-to-back: second start in the IDLE cycle right after DONE
    launch(32'h0000_0001, 32'h0000_0002, 1'b0);
    first  = -1;
    second = -1;
    s2     = '0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 10) begin
        a_i   = 32'h0000_0003;
        b_i   = 32'h0000_0004;
        cin_i = 1'b0;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done) begin
        if (first < 0) begin
          first = i;
          s = sum;
        end else if (second < 0) begin
          second = i;
          s2 = sum;
        end
      end
    end
    chk("b2b.first", first, 8);
    chk("b2b.sum1", s, 32'h3);
    chk("b2b.gap", second - first, 10);
    chk("b2b.sum2", s2, 32'h7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder_32_bit.md
SERIAL_ADDER_32_BIT -- requirements
Module: serial_adder_32_bit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter DIGIT, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 Port clock  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port clear  input  1: reset, synchronous and active-high.
REQ-005 Port start  input  1: request to latch a, b and cin and begin an addition.
REQ-006 Port a  input  WIDTH: first operand.
REQ-007 Port b  input  WIDTH: second operand.
REQ-008 Port cin  input  1: carry into bit 0.
REQ-009 Port sum  output  WIDTH: registered result a + b + cin, modulo 2^WIDTH.
REQ-010 Port cout  output  1: registered carry out of bit WIDTH-1.
REQ-011 Port overflow  output  1: registered two's-complement overflow, i.e. a[MSB] == b[MSB] and sum[MSB] != a[MSB].
REQ-012 Port busy  output  1: high while an addition is in progress.
REQ-013 Port done  output  1: one-cycle pulse indicating that sum, cout and overflow are valid.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL latch a, b and cin into internal operand shift registers and the carry flop, clear the digit counter, and enter RUN.
REQ-016 In IDLE with start=0, the state and all outputs SHALL hold.
REQ-017 In RUN, each edge SHALL add the low DIGIT bits of both operand registers plus the carry flop, shift the DIGIT-bit result into the sum register from the MSB end, store the digit carry, shift both operands right by DIGIT, and increment the counter.
REQ-018 After WIDTH/DIGIT RUN edges (8 at default), the FSM SHALL enter DONE with sum, cout and overflow final.
REQ-019 Latency: start sampled at edge N SHALL cause done=1 during the cycle following edge N+8 (default parameters).
REQ-020 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-021 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-022 done SHALL be 1 only in DONE.
REQ-023 start SHALL be ignored in RUN and DONE; no requests SHALL be queued.
REQ-024 sum, cout and overflow SHALL hold their last result from DONE until the next start is accepted.
REQ-025 During RUN, sum, cout and overflow SHALL be treated as undefined by users; only done qualifies them.
REQ-026 Changes on a, b or cin after the start edge SHALL NOT affect the result in progress.
REQ-027 Subtraction SHALL be performed by the user as a + ~b with cin=1; cout=1 then indicates no borrow.

Reset
REQ-028 On clear=1 at a rising edge, the block SHALL set the state to IDLE and force sum=0, cout=0, overflow=0, busy=0, done=0, counter=0 and carry=0, from any state.
REQ-029 clear SHALL take priority over start when both are high at the same edge.
REQ-030 A clear asserted mid-RUN SHALL abort the operation with no done pulse.

Structure
REQ-031 A shared package SHALL hold the WIDTH and DIGIT defaults, the derived STEPS = WIDTH/DIGIT, and the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
REQ-032 The per-digit addition SHALL be one combinational sub-module, adder_4_bit (inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout), instantiated once.

Verification
REQ-033 a=0x00000004, b=0x00000002, cin=0, start pulsed at edge N -> done=1 after edge N+8, sum=0x00000006, cout=0, overflow=0.
REQ-034 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, overflow=0.
REQ-035 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1.
REQ-036 a=0x04444444, b=~0x04444444=0xFBBBBBBB, cin=1 -> sum=0x00000000, cout=1; second start pulsed during RUN -> exactly one done pulse.
REQ-037 Run with a=0x12345678, b=0x11111111, cin=0; assert clear at the 4th RUN edge -> next cycle busy=0, done=0, sum=0; no done pulse within the following 10 cycles.
REQ-038 Back-to-back operation: start asserted in the IDLE cycle immediately after DONE -> accepted, with second done exactly 10 cycles after the first.
